// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked sequential adder/subtractor.
package adder_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} madd_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; exposes the carry into the top bit for overflow.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder/subtractor: CHUNK bits per cycle, LSB chunk first, valid/ready on both sides.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH <= 0 || CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    madd_state_e      state, state_next;
    logic [WIDTH-1:0] op_a, op_b;
    logic             carry;
    logic [CW-1:0]    idx;
    logic             accept, last;
    logic [WIDTH-1:0] a_shift, b_shift;
    logic [CHUNK-1:0] sum_k;
    logic             cout_k, cmsb_k;

    assign last   = (idx == CW'(NCHUNK - 1));
    assign accept = in_valid & in_ready;

    // Chunk select by shifting the operand down rather than a variable part-select.
    assign a_shift = op_a >> (int'(idx) * CHUNK);
    assign b_shift = op_b >> (int'(idx) * CHUNK);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_shift[CHUNK-1:0]),
        .b     (b_shift[CHUNK-1:0]),
        .cin   (carry),
        .sum   (sum_k),
        .cout  (cout_k),
        .c_msb (cmsb_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Taking the result frees the block in the same cycle.
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction as a + ~b + 1; borrow-in folds into the inverted carry.
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            idx   <= '0;
        end else if (state == CALC) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (idx == CW'(k)) s[k*CHUNK +: CHUNK] <= sum_k;
            end
            carry <= cout_k;
            idx   <= last ? '0 : idx + CW'(1);
            if (last) begin
                cout <= cout_k;
                ovf  <= cmsb_k ^ cout_k;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder at CHUNK = 1, 8, 32 (WIDTH 32): vector table, handshake corners, random scoreboard.
module tb_multicycle_adder;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iv[3], ir[3], ov[3], ordy[3];
    logic          sub_i[3], cin_i[3], co_o[3], of_o[3];
    logic [W-1:0]  a_i[3], b_i[3], s_o[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int C = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
        multicycle_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (a_i[g]),
            .b         (b_i[g]),
            .sub       (sub_i[g]),
            .cin       (cin_i[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .s         (s_o[g]),
            .cout      (co_o[g]),
            .ovf       (of_o[g])
        );
    end

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub, cin;
        logic [W-1:0] s;
        logic         co, of;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         co, of;
        int           e;
    } exp_t;

    function automatic int nch(input int d);
        return (d == 0) ? 32 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sb, input logic ci,
                                   output logic [W-1:0] s, output logic co, output logic of);
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint c = ci ? 64'sd1 : 64'sd0;
        longint r, sr;
        if (!sb) begin
            r  = ua + ub + c;
            sr = sa + sbv + c;
            co = (r > 64'sh0_FFFF_FFFF);
        end else begin
            r  = ua - ub - c;
            sr = sa - sbv - c;
            co = (r >= 0);
        end
        s  = r[W-1:0];
        of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    task automatic do_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sb, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic of,
                         output int lat);
        int w = 0;
        @(negedge clk);
        a_i[d] = a; b_i[d] = b; sub_i[d] = sb; cin_i[d] = ci;
        iv[d] = 1'b1; ordy[d] = 1'b1;
        #1;
        while (!ir[d] && w < 20) begin
            @(negedge clk); #1; w++;
        end
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0; a_i[d] = $urandom; b_i[d] = $urandom; sub_i[d] = ~sb; cin_i[d] = ~ci;
        lat = 0;
        while (!ov[d] && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        s = s_o[d]; co = co_o[d]; of = of_o[d];
    endtask

    task automatic run_random(input int d, input int nops);
        exp_t   q[$];
        exp_t   e;
        int     cyc = 0, done = 0, issued = 0;
        int     budget = nops * (nch(d) + 10) + 200;
        bit     pend = 0, seen = 0;
        logic [W-1:0] rs;
        logic   rc, ro;
        iv[d] = 1'b0; ordy[d] = 1'b0;
        while (done < nops && cyc < budget) begin
            @(negedge clk);
            ordy[d] = ($urandom_range(3) != 0);
            if (!pend) begin
                a_i[d] = $urandom; b_i[d] = $urandom;
                sub_i[d] = 1'($urandom_range(1)); cin_i[d] = 1'($urandom_range(1));
                case ($urandom_range(7))
                    0: a_i[d] = 32'h7FFF_FFFF;
                    1: a_i[d] = 32'h8000_0000;
                    2: b_i[d] = 32'hFFFF_FFFF;
                    default: ;
                endcase
                if (issued < nops && $urandom_range(3) != 0) begin
                    pend = 1; iv[d] = 1'b1;
                end else iv[d] = 1'b0;
            end
            #1;
            if (ov[d]) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_valid", 64'(ov[d]), 64'd0);
                end else begin
                    if (!seen) begin
                        seen = 1;
                        chk("rnd_latency", 64'(cyc - q[0].e), 64'(nch(d)));
                    end
                    if (ordy[d]) begin
                        e = q.pop_front();
                        chk("rnd_result", {30'b0, co_o[d], of_o[d], s_o[d]}, {30'b0, e.co, e.of, e.s});
                        done++; seen = 0;
                    end
                end
            end
            if (iv[d] && ir[d]) begin
                ref_op(a_i[d], b_i[d], sub_i[d], cin_i[d], rs, rc, ro);
                e.s = rs; e.co = rc; e.of = ro; e.e = cyc + 1;
                q.push_back(e);
                pend = 0; issued++;
            end
            @(posedge clk); cyc++;
        end
        if (done < nops) chk("rnd_timeout_done", 64'(done), 64'(nops));
        @(negedge clk);
        iv[d] = 1'b0; ordy[d] = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] rs, hs;
        logic         rc, ro;
        int           lat, n, any;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000D, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; a_i[d] = '0; b_i[d] = '0; sub_i[d] = 1'b0; cin_i[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk("reset_outputs", {29'b0, ov[d], co_o[d], of_o[d], s_o[d]}, 64'd0);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk("reset_in_ready", 64'(ir[d]), 64'd1);

        // Vector table on every chunk size
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                do_op(d, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, rs, rc, ro, lat);
                chk("vec_s", 64'(rs), 64'(vecs[i].s));
                chk("vec_cout", 64'(rc), 64'(vecs[i].co));
                chk("vec_ovf", 64'(ro), 64'(vecs[i].of));
                chk("vec_latency", 64'(lat), 64'(nch(d)));
            end
        end

        // Stalled result, then take it and accept a new op in the same cycle (CHUNK=8)
        @(negedge clk);
        a_i[1] = 32'h1111_1111; b_i[1] = 32'h2222_2222; sub_i[1] = 1'b0; cin_i[1] = 1'b0;
        iv[1] = 1'b1; ordy[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0; a_i[1] = $urandom; b_i[1] = $urandom;
        n = 0;
        while (!ov[1] && n < 50) begin
            @(negedge clk); n++;
        end
        hs = s_o[1];
        for (int k = 0; k < 10; k++) begin
            chk("stall_hold", {31'b0, ov[1], ir[1], s_o[1]}, {31'b0, 1'b1, 1'b0, 32'h3333_3333});
            @(negedge clk);
        end
        chk("stall_s_stable", 64'(s_o[1]), 64'(hs));
        a_i[1] = 32'hFFFF_FFFF; b_i[1] = 32'hFFFF_FFFF; sub_i[1] = 1'b1; cin_i[1] = 1'b0;
        iv[1] = 1'b1; ordy[1] = 1'b1;
        #1;
        chk("take_and_accept_ready", 64'(ir[1]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0; a_i[1] = $urandom; b_i[1] = $urandom;
        chk("b2b_valid_dropped", 64'(ov[1]), 64'd0);
        lat = 0;
        while (!ov[1] && lat < 100) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk("b2b_latency", 64'(lat), 64'd4);
        chk("b2b_result", {30'b0, co_o[1], of_o[1], s_o[1]}, {30'b0, 1'b1, 1'b0, 32'h0});

        // Reset during CALC with idx==2 aborts the op
        @(negedge clk);
        a_i[1] = 32'hFFFF_FFFF; b_i[1] = 32'hFFFF_FFFF; sub_i[1] = 1'b0; cin_i[1] = 1'b0;
        iv[1] = 1'b1; ordy[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {29'b0, ov[1], co_o[1], of_o[1], s_o[1]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 64'(ir[1]), 64'd1);
        any = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov[1]) any = 1;
        end
        chk("abort_no_result", 64'(any), 64'd0);

        // Random scoreboard per chunk size
        for (int d = 0; d < 3; d++) run_random(d, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
